debug_ctrl: RTL and testbench
=============================

DEBUG_CTRL -- requirements
Module: debug_ctrl

Interface
REQ-001 Parameters SHALL be: CORES, default 4, number of cores behind the debug mux; LOG_CORES, default 2, core-select width; DATA_WIDTH, default 8, register width; TIMEOUT_CYCLES, default 15, halt-poll limit (1..15).
REQ-002 Ports SHALL be (name  direction  width  meaning): clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-003 Host request ports SHALL be: req_valid  in  1; req_ready  out  1; req_core  in  LOG_CORES; req_reg  in  4  register index; req_we  in  1  1 = write; req_wdata  in  DATA_WIDTH; req_halt  in  1  1 = halt core around access.
REQ-004 Host response ports SHALL be: resp_valid  out  1  single-cycle pulse; resp_rdata  out  DATA_WIDTH; resp_err  out  1  halt timeout.
REQ-005 Debug-mux ports SHALL be: sel  out  LOG_CORES; addr  out  5; we  out  1; wdata  out  DATA_WIDTH; rdata  in  DATA_WIDTH, combinational from addr/sel.
REQ-006 Mux address map SHALL be: addr[4]=0 selects register addr[3:0]; addr=5'b10000 write sets cpu_mode=wdata[1:0] (2'b00 run, 2'b01 stop); addr=5'b10000 read returns stopped flag in rdata[0].

Function
REQ-007 States SHALL be IDLE, HALT, POLL, ACCESS, RESUME, RESP.
REQ-008 req_ready SHALL be 1 only in IDLE; a request is accepted on clk when req_valid&req_ready; core, reg, we, wdata, halt are latched on acceptance.
REQ-009 IDLE SHALL go to HALT if latched halt=1, else ACCESS.
REQ-010 HALT SHALL drive sel=core, addr=5'b10000, we=1, wdata=2'b01 (zero-extended) for exactly one cycle, then enter POLL with timeout counter cleared.
REQ-011 POLL SHALL drive addr=5'b10000, we=0; if rdata[0]=1 go to ACCESS next cycle, else increment counter.
REQ-012 ACCESS SHALL last one cycle driving sel=core, addr={1'b0,reg}; on write we=1, wdata=latched data; on read we=0 and rdata is captured into resp_rdata at that clock edge.
REQ-013 After ACCESS, state SHALL go to RESUME if halt=1, else RESP.
REQ-014 RESUME SHALL drive addr=5'b10000, we=1, wdata=0 (run) for one cycle, then RESP.
REQ-015 RESP SHALL assert resp_valid for exactly one cycle, then IDLE; resp_rdata holds until next read completes; for writes resp_rdata is unchanged.
REQ-016 Latency, acceptance to resp_valid: no halt 2 cycles; halt with stop seen on first poll 5 cycles; each extra poll adds 1.
REQ-017 In IDLE, POLL, RESP outputs SHALL hold we=0; we SHALL never be 1 outside HALT, ACCESS(write), RESUME.
REQ-018 In IDLE sel and addr SHALL hold last values; wdata=0 when we=0.
REQ-019 resp_err SHALL be valid only with resp_valid; 0 for all successful transactions.
REQ-020 req_valid while not ready SHALL be ignored without side effect; no queuing.

Reset
REQ-021 On rst at clk: state IDLE, req_ready=1 in following cycle, resp_valid=0, resp_err=0, resp_rdata=0, sel=0, addr=0, we=0, wdata=0, counter=0.
REQ-022 Reset mid-transaction SHALL abort without issuing RESUME; core mode left as-is is the host's responsibility.

Configuration
REQ-023 Macro DEBUG_CTRL_TIMEOUT_EN defined: when POLL counter reaches TIMEOUT_CYCLES with rdata[0]=0, go to RESUME (skip ACCESS), then RESP with resp_err=1, resp_rdata unchanged.
REQ-024 Macro undefined: POLL SHALL wait indefinitely; counter logic absent; resp_err tied 0.

Verification
REQ-025 No-halt read: core=2, reg=4'h3, rdata=8'hC3 -> sel=2, addr=5'b00011, we=0, resp_valid 2 cycles after acceptance, resp_rdata=8'hC3, resp_err=0.
REQ-026 Halt write: core=1, reg=4'hC, wdata=8'hAA, stopped after 3 polls -> sequence: mode write 8'h01, 3 polls, write addr=5'b01100 wdata=8'hAA, mode write 8'h00, resp_valid, latency 7.
REQ-027 Timeout (macro on, TIMEOUT_CYCLES=15): stopped never set -> 15 polls, no register write, RESUME write 8'h00, resp_err=1.
REQ-028 Back-to-back: req_valid held with two requests -> second accepted only on the cycle req_ready returns after RESP; second request not lost or duplicated.
REQ-029 Reset in POLL: rst one cycle -> we=0, resp_valid=0, req_ready=1 next cycle, no RESUME write.

Source files
------------

// File: rtl/debug_ctrl.sv
// debug_ctrl
//   Host-side controller for a multi-core debug mux. It accepts one register
//   access at a time. If the host asks for it, the controller halts the target
//   core around the access: it writes the stop mode, polls the stopped flag,
//   performs the access, then writes the run mode back.
//
//   Optional feature: when DEBUG_CTRL_TIMEOUT_EN is defined, polling gives up
//   after TIMEOUT_CYCLES polls. The controller then resumes the core and
//   answers with resp_err=1. When the macro is undefined, polling waits
//   indefinitely and resp_err is tied to 0.
//
//   Ports
//     clk, rst                    clock, synchronous active-high reset
//     req_valid/req_ready         host request handshake (ready only in IDLE)
//     req_core, req_reg, req_we,
//     req_wdata, req_halt         request fields, latched on acceptance
//     resp_valid                  single-cycle response pulse
//     resp_rdata                  last read data (holds between reads)
//     resp_err                    halt timeout, qualified by resp_valid
//     sel, addr, we, wdata        debug-mux access bus
//     rdata                       debug-mux read data, combinational from sel/addr
//
//   state  | meaning
//   IDLE   | waiting for a host request, req_ready=1
//   HALT   | one-cycle write of stop mode (2'b01) to the mode register
//   POLL   | reading the stopped flag until it sets (or times out)
//   ACCESS | one-cycle register read or write
//   RESUME | one-cycle write of run mode (2'b00)
//   RESP   | resp_valid pulse
module debug_ctrl #(
    parameter int CORES          = 4,
    parameter int LOG_CORES      = 2,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [LOG_CORES-1:0]  req_core,
    input  logic [3:0]            req_reg,
    input  logic                  req_we,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic                  req_halt,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [LOG_CORES-1:0]  sel,
    output logic [4:0]            addr,
    output logic                  we,
    output logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata
);

    localparam logic [4:0] MODE_ADDR = 5'b10000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_POLL,
        S_ACCESS,
        S_RESUME,
        S_RESP
    } state_t;

    state_t state, state_nxt;

    logic [LOG_CORES-1:0]  core_q;
    logic [LOG_CORES-1:0]  sel_q;
    logic [3:0]            reg_q;
    logic [4:0]            addr_q;
    logic                  we_q;
    logic                  halt_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [LOG_CORES-1:0]  core_in;
    logic                  tmo;

    // A select code with no core behind it is redirected to core 0.
    generate
        if (CORES < (1 << LOG_CORES)) begin : g_clamp
            assign core_in = (req_core < LOG_CORES'(CORES)) ? req_core : '0;
        end else begin : g_full
            assign core_in = req_core;
        end
    endgenerate

`ifdef DEBUG_CTRL_TIMEOUT_EN
    logic [3:0] poll_cnt;

    // The counter holds the number of failed polls before the current one.
    // A miss on the last allowed poll gives up.
    assign tmo = (state == S_POLL) && !rdata[0] &&
                 (poll_cnt == 4'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            poll_cnt <= '0;
        end else if (state == S_HALT) begin
            poll_cnt <= '0;
        end else if (state == S_POLL && !rdata[0] && !tmo) begin
            poll_cnt <= poll_cnt + 4'd1;
        end
    end
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        sel        = sel_q;
        addr       = addr_q;
        we         = 1'b0;
        wdata      = '0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = req_halt ? S_HALT : S_ACCESS;
                end
            end
            S_HALT: begin
                sel       = core_q;
                addr      = MODE_ADDR;
                we        = 1'b1;
                wdata     = DATA_WIDTH'(2'b01);
                state_nxt = S_POLL;
            end
            S_POLL: begin
                sel  = core_q;
                addr = MODE_ADDR;
                if (rdata[0]) begin
                    state_nxt = S_ACCESS;
                end else if (tmo) begin
                    state_nxt = S_RESUME;
                end
            end
            S_ACCESS: begin
                sel       = core_q;
                addr      = {1'b0, reg_q};
                we        = we_q;
                wdata     = we_q ? wdata_q : '0;
                state_nxt = halt_q ? S_RESUME : S_RESP;
            end
            S_RESUME: begin
                sel       = core_q;
                addr      = MODE_ADDR;
                we        = 1'b1;
                wdata     = '0;
                state_nxt = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = resp_valid & err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            sel_q   <= '0;
            addr_q  <= '0;
            core_q  <= '0;
            reg_q   <= '0;
            we_q    <= 1'b0;
            halt_q  <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state  <= state_nxt;
            // The bus remembers its last sel/addr so IDLE and RESP can hold them.
            sel_q  <= sel;
            addr_q <= addr;
            if (state == S_IDLE && req_valid) begin
                core_q  <= core_in;
                reg_q   <= req_reg;
                we_q    <= req_we;
                wdata_q <= req_wdata;
                halt_q  <= req_halt;
                err_q   <= 1'b0;
            end
            if (state == S_ACCESS && !we_q) begin
                rdata_q <= rdata;
            end
            if (tmo) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_debug_ctrl.sv
module tb_debug_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_core;
    logic [3:0] req_reg;
    logic       req_we;
    logic [7:0] req_wdata;
    logic       req_halt;
    logic       resp_valid;
    logic [7:0] resp_rdata;
    logic       resp_err;
    logic [1:0] sel;
    logic [4:0] addr;
    logic       we;
    logic [7:0] wdata;
    logic [7:0] rdata;

    always #5 clk = ~clk;

    debug_ctrl #(
        .CORES(4), .LOG_CORES(2), .DATA_WIDTH(8), .TIMEOUT_CYCLES(15)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_core(req_core),
        .req_reg(req_reg), .req_we(req_we), .req_wdata(req_wdata), .req_halt(req_halt),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .sel(sel), .addr(addr), .we(we), .wdata(wdata), .rdata(rdata)
    );

    // Debug-mux model: register file per core, mode per core, stopped flag that
    // appears on the stop_after-th poll (never when stop_after is 0).
    logic [7:0]  regs [0:3][0:15];
    logic [3:0]  mode_stop;
    logic [14:0] wlog [0:63];
    int          wr_cnt     = 0;
    int          poll_total = 0;
    int          poll_base  = 0;
    int          stop_after = 0;
    logic        stopped;

    assign stopped = mode_stop[sel] && (stop_after != 0) &&
                     ((poll_total - poll_base + 1) >= stop_after);
    assign rdata   = addr[4] ? {7'b0, stopped} : regs[sel][addr[3:0]];

    always @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 16; r++)
                    regs[c][r] <= 8'h40 + 8'(c * 16 + r);
            regs[2][3] <= 8'hC3;
            mode_stop  <= '0;
        end else if (we) begin
            if (wr_cnt < 64) wlog[wr_cnt] <= {sel, addr, wdata};
            wr_cnt <= wr_cnt + 1;
            if (addr == 5'b10000) mode_stop[sel] <= (wdata[1:0] == 2'b01);
            else if (!addr[4]) regs[sel][addr[3:0]] <= wdata;
        end else if (addr == 5'b10000 && mode_stop[sel]) begin
            poll_total <= poll_total + 1;
        end
    end

    int         vectors     = 0;
    int         miscompares = 0;
    logic [1:0] a_sel;
    logic [4:0] a_addr;
    logic       a_we;

    task automatic run_req(input logic [1:0] c, input logic [3:0] r, input logic w,
                           input logic [7:0] d, input logic h, input int sa,
                           output int lat, output int wbase, output int pbase);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        stop_after = sa;
        poll_base  = poll_total;
        pbase      = poll_total;
        wbase      = wr_cnt;
        req_core = c; req_reg = r; req_we = w; req_wdata = d; req_halt = h;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                a_sel = sel; a_addr = addr; a_we = we;
            end
            if (resp_valid) break;
        end
        if (!resp_valid) begin
            vectors++; miscompares++;
            $display("FAIL resp_wait: resp_valid not seen in %0d cycles, required within bound", lat);
            lat = -1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_core = '0; req_reg = '0;
        req_we = 1'b0; req_wdata = '0; req_halt = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready: got %b required 1", req_ready); end
        vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_resp_valid: got %b required 0", resp_valid); end
        vectors++; if (resp_err !== 1'b0) begin miscompares++; $display("FAIL rst_resp_err: got %b required 0", resp_err); end
        vectors++; if (resp_rdata !== 8'h00) begin miscompares++; $display("FAIL rst_resp_rdata: got %h required 00", resp_rdata); end
        vectors++; if (sel !== 2'd0) begin miscompares++; $display("FAIL rst_sel: got %0d required 0", sel); end
        vectors++; if (addr !== 5'd0) begin miscompares++; $display("FAIL rst_addr: got %b required 00000", addr); end
        vectors++; if (we !== 1'b0) begin miscompares++; $display("FAIL rst_we: got %b required 0", we); end
        vectors++; if (wdata !== 8'h00) begin miscompares++; $display("FAIL rst_wdata: got %h required 00", wdata); end
    endtask

    task automatic test_read_nohalt();
        int lat, wb, pb;
        run_req(2'd2, 4'h3, 1'b0, 8'h00, 1'b0, 0, lat, wb, pb);
        vectors++; if (a_sel !== 2'd2) begin miscompares++; $display("FAIL rd_sel: got %0d required 2", a_sel); end
        vectors++; if (a_addr !== 5'b00011) begin miscompares++; $display("FAIL rd_addr: got %b required 00011", a_addr); end
        vectors++; if (a_we !== 1'b0) begin miscompares++; $display("FAIL rd_we: got %b required 0", a_we); end
        vectors++; if (lat != 2) begin miscompares++; $display("FAIL rd_latency: got %0d required 2", lat); end
        vectors++; if (resp_rdata !== 8'hC3) begin miscompares++; $display("FAIL rd_data: got %h required c3", resp_rdata); end
        vectors++; if (resp_err !== 1'b0) begin miscompares++; $display("FAIL rd_err: got %b required 0", resp_err); end
        vectors++; if (wr_cnt != wb) begin miscompares++; $display("FAIL rd_no_write: got %0d writes required 0", wr_cnt - wb); end
        @(negedge clk);
        vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL rd_pulse: got %b required 0", resp_valid); end
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rd_ready_back: got %b required 1", req_ready); end
        vectors++; if (addr !== 5'b00011) begin miscompares++; $display("FAIL rd_addr_hold: got %b required 00011", addr); end
    endtask

    task automatic test_halt_write();
        int lat, wb, pb;
        run_req(2'd1, 4'hC, 1'b1, 8'hAA, 1'b1, 3, lat, wb, pb);
        vectors++; if (lat != 7) begin miscompares++; $display("FAIL hw_latency: got %0d required 7", lat); end
        vectors++; if (wr_cnt - wb != 3) begin miscompares++; $display("FAIL hw_writes: got %0d required 3", wr_cnt - wb); end
        vectors++; if (wlog[wb] !== {2'd1, 5'b10000, 8'h01}) begin miscompares++; $display("FAIL hw_stop_wr: got %h required %h", wlog[wb], {2'd1, 5'b10000, 8'h01}); end
        vectors++; if (wlog[wb+1] !== {2'd1, 5'b01100, 8'hAA}) begin miscompares++; $display("FAIL hw_reg_wr: got %h required %h", wlog[wb+1], {2'd1, 5'b01100, 8'hAA}); end
        vectors++; if (wlog[wb+2] !== {2'd1, 5'b10000, 8'h00}) begin miscompares++; $display("FAIL hw_run_wr: got %h required %h", wlog[wb+2], {2'd1, 5'b10000, 8'h00}); end
        vectors++; if (poll_total - pb != 3) begin miscompares++; $display("FAIL hw_polls: got %0d required 3", poll_total - pb); end
        vectors++; if (resp_rdata !== 8'hC3) begin miscompares++; $display("FAIL hw_rdata_hold: got %h required c3", resp_rdata); end
        vectors++; if (resp_err !== 1'b0) begin miscompares++; $display("FAIL hw_err: got %b required 0", resp_err); end
    endtask

    task automatic test_halt_read();
        int lat, wb, pb;
        run_req(2'd1, 4'hC, 1'b0, 8'h00, 1'b1, 1, lat, wb, pb);
        vectors++; if (lat != 5) begin miscompares++; $display("FAIL hr_latency: got %0d required 5", lat); end
        vectors++; if (resp_rdata !== 8'hAA) begin miscompares++; $display("FAIL hr_data: got %h required aa", resp_rdata); end
        vectors++; if (poll_total - pb != 1) begin miscompares++; $display("FAIL hr_polls: got %0d required 1", poll_total - pb); end
        vectors++; if (wr_cnt - wb != 2) begin miscompares++; $display("FAIL hr_writes: got %0d required 2", wr_cnt - wb); end
    endtask

    task automatic test_write_nohalt();
        int lat, wb, pb;
        run_req(2'd0, 4'h5, 1'b1, 8'h5A, 1'b0, 0, lat, wb, pb);
        vectors++; if (lat != 2) begin miscompares++; $display("FAIL wn_latency: got %0d required 2", lat); end
        vectors++; if (wlog[wb] !== {2'd0, 5'b00101, 8'h5A}) begin miscompares++; $display("FAIL wn_wr: got %h required %h", wlog[wb], {2'd0, 5'b00101, 8'h5A}); end
        vectors++; if (resp_rdata !== 8'hAA) begin miscompares++; $display("FAIL wn_rdata_hold: got %h required aa", resp_rdata); end
        run_req(2'd0, 4'h5, 1'b0, 8'h00, 1'b0, 0, lat, wb, pb);
        vectors++; if (resp_rdata !== 8'h5A) begin miscompares++; $display("FAIL wn_readback: got %h required 5a", resp_rdata); end
    endtask

`ifdef DEBUG_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        int lat, wb, pb;
        run_req(2'd3, 4'h2, 1'b1, 8'h77, 1'b1, 0, lat, wb, pb);
        vectors++; if (lat != 18) begin miscompares++; $display("FAIL to_latency: got %0d required 18", lat); end
        vectors++; if (poll_total - pb != 15) begin miscompares++; $display("FAIL to_polls: got %0d required 15", poll_total - pb); end
        vectors++; if (wr_cnt - wb != 2) begin miscompares++; $display("FAIL to_writes: got %0d required 2", wr_cnt - wb); end
        vectors++; if (wlog[wb+1] !== {2'd3, 5'b10000, 8'h00}) begin miscompares++; $display("FAIL to_run_wr: got %h required %h", wlog[wb+1], {2'd3, 5'b10000, 8'h00}); end
        vectors++; if (resp_err !== 1'b1) begin miscompares++; $display("FAIL to_err: got %b required 1", resp_err); end
        vectors++; if (resp_rdata !== 8'h5A) begin miscompares++; $display("FAIL to_rdata_hold: got %h required 5a", resp_rdata); end
        run_req(2'd3, 4'h2, 1'b0, 8'h00, 1'b0, 0, lat, wb, pb);
        vectors++; if (resp_rdata !== 8'h72) begin miscompares++; $display("FAIL to_after_data: got %h required 72", resp_rdata); end
        vectors++; if (resp_err !== 1'b0) begin miscompares++; $display("FAIL to_after_err: got %b required 0", resp_err); end
    endtask
`else
    task automatic test_long_poll();
        int lat, wb, pb;
        run_req(2'd3, 4'h2, 1'b1, 8'h77, 1'b1, 20, lat, wb, pb);
        vectors++; if (lat != 24) begin miscompares++; $display("FAIL lp_latency: got %0d required 24", lat); end
        vectors++; if (poll_total - pb != 20) begin miscompares++; $display("FAIL lp_polls: got %0d required 20", poll_total - pb); end
        vectors++; if (wlog[wb+1] !== {2'd3, 5'b00010, 8'h77}) begin miscompares++; $display("FAIL lp_reg_wr: got %h required %h", wlog[wb+1], {2'd3, 5'b00010, 8'h77}); end
        vectors++; if (resp_err !== 1'b0) begin miscompares++; $display("FAIL lp_err: got %b required 0", resp_err); end
    endtask
`endif

    task automatic test_back_to_back();
        int nresp, acc_b, accb_at;
        logic [7:0] r0, r1;
        nresp = 0; acc_b = 0; accb_at = -1; r0 = '0; r1 = '0;
        stop_after = 0;
        @(negedge clk);
        req_core = 2'd0; req_reg = 4'h6; req_we = 1'b0; req_wdata = 8'h00; req_halt = 1'b0;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_core = 2'd2; req_reg = 4'h3;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                if (nresp == 0) r0 = resp_rdata; else r1 = resp_rdata;
                nresp++;
            end
            if (req_valid && req_ready) begin
                acc_b++;
                accb_at = i;
                @(posedge clk);
                #1 req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        vectors++; if (nresp != 2) begin miscompares++; $display("FAIL b2b_resps: got %0d required 2", nresp); end
        vectors++; if (acc_b != 1) begin miscompares++; $display("FAIL b2b_accepts: got %0d required 1", acc_b); end
        vectors++; if (accb_at != 3) begin miscompares++; $display("FAIL b2b_accept_cycle: got %0d required 3", accb_at); end
        vectors++; if (r0 !== 8'h46) begin miscompares++; $display("FAIL b2b_first_data: got %h required 46", r0); end
        vectors++; if (r1 !== 8'hC3) begin miscompares++; $display("FAIL b2b_second_data: got %h required c3", r1); end
    endtask

    task automatic test_reset_in_poll();
        int wb, bad;
        bad = 0;
        @(negedge clk);
        stop_after = 0;
        poll_base  = poll_total;
        wb         = wr_cnt;
        req_core = 2'd3; req_reg = 4'h1; req_we = 1'b1; req_wdata = 8'h11; req_halt = 1'b1;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++; if (we !== 1'b0) begin miscompares++; $display("FAIL rp_we: got %b required 0", we); end
        vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL rp_resp_valid: got %b required 0", resp_valid); end
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rp_ready: got %b required 1", req_ready); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (resp_valid || we) bad++;
        end
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL rp_quiet: got %0d active cycles required 0", bad); end
        vectors++; if (wr_cnt - wb != 1) begin miscompares++; $display("FAIL rp_no_resume: got %0d writes required 1", wr_cnt - wb); end
    endtask

    initial begin
        test_reset();
        test_read_nohalt();
        test_halt_write();
        test_halt_read();
        test_write_nohalt();
`ifdef DEBUG_CTRL_TIMEOUT_EN
        test_timeout();
`else
        test_long_poll();
`endif
        test_back_to_back();
        test_reset_in_poll();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
